// File: rtl/fwd_hazard_unit_pkg.sv
// Shared CPU pipeline constants used by the forwarding/hazard logic:
// stage indices and the width of the tnew/tuse timing fields.
package fwd_hazard_unit_pkg;

   localparam int STG_E = 0;
   localparam int STG_M = 1;
   localparam int STG_W = 2;

   localparam int TW = 2;

   // Result-ready countdown moves one step closer each cycle, never below zero.
   function automatic logic [TW-1:0] tnew_dec(input logic [TW-1:0] tnew);
      logic [TW-1:0] res;
      if (tnew == {TW{1'b0}}) begin
         res = {TW{1'b0}};
      end else begin
         res = tnew - {{(TW-1){1'b0}}, 1'b1};
      end
      return res;
   endfunction

endpackage

// File: rtl/fwd_port_sel.sv
// Per-read-port operand selection: finds the youngest in-flight producer of the
// source register and either forwards its data, asks for a stall, or falls back to the RF.
module fwd_port_sel
   import fwd_hazard_unit_pkg::*;
#(
   parameter int NSTAGE = 3,
   parameter int DW     = 32,
   parameter int AW     = 5
) (
   input  logic [AW-1:0]        addr,
   input  logic [TW-1:0]        tuse,
   input  logic [DW-1:0]        rf_data,
   input  logic [NSTAGE*AW-1:0] stg_waddr,
   input  logic [NSTAGE*TW-1:0] stg_tnew,
   input  logic [NSTAGE*DW-1:0] stg_wdata,
   output logic [DW-1:0]        data,
   output logic [NSTAGE-1:0]    hit,
   output logic                 stall_req
);

   logic found_s;

   // Youngest matching stage wins; once found, older stages are ignored.
   always_comb begin
      data      = rf_data;
      hit       = {NSTAGE{1'b0}};
      stall_req = 1'b0;
      found_s   = 1'b0;
      if (addr != {AW{1'b0}}) begin
         for (int s = 0; s < NSTAGE; s++) begin
            if (!found_s && (stg_waddr[s*AW +: AW] == addr)) begin
               found_s = 1'b1;
               if (stg_tnew[s*TW +: TW] == {TW{1'b0}}) begin
                  data   = stg_wdata[s*DW +: DW];
                  hit[s] = 1'b1;
               end else if (stg_tnew[s*TW +: TW] > tuse) begin
                  stall_req = 1'b1;
               end else begin
                  // Producer finishes in time for the consumer; operand is picked up later.
                  data = rf_data;
               end
            end else begin
               found_s = found_s;
            end
         end
      end else begin
         data = rf_data;
      end
   end

endmodule

// File: rtl/fwd_hazard_unit.sv
// Forwarding and hazard unit: tracks destination/tnew of in-flight instructions,
// selects forwarded operands per read port and raises stall for data and mult/div hazards.
module fwd_hazard_unit
   import fwd_hazard_unit_pkg::*;
#(
   parameter int NPORT  = 2,
   parameter int NSTAGE = 3,
   parameter int DW     = 32,
   parameter int AW     = 5,
   parameter int MD_LAT = 5
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    iss_valid,
   input  logic [AW-1:0]           iss_waddr,
   input  logic [TW-1:0]           iss_tnew,
   input  logic [NPORT*AW-1:0]     rd_addr,
   input  logic [NPORT*TW-1:0]     rd_tuse,
   input  logic [NPORT*DW-1:0]     rf_rdata,
   input  logic [NSTAGE*DW-1:0]    stg_wdata,
   input  logic                    md_start,
   input  logic                    md_use,
   output logic [NPORT*DW-1:0]     fwd_data,
   output logic [NPORT*NSTAGE-1:0] fwd_hit,
   output logic                    stall,
   output logic                    md_busy
);

   // A zero-latency mult/div still needs a one-bit counter that simply stays at zero.
   localparam int CW = (MD_LAT > 0) ? $clog2(MD_LAT + 1) : 1;

   logic [AW-1:0]        waddr_r [NSTAGE];
   logic [TW-1:0]        tnew_r  [NSTAGE];
   logic [CW-1:0]        md_cnt_r;
   logic [NSTAGE*AW-1:0] stg_waddr_s;
   logic [NSTAGE*TW-1:0] stg_tnew_s;
   logic [NPORT-1:0]     port_stall_s;
   logic                 md_load_s;

   for (genvar s = 0; s < NSTAGE; s++) begin : g_pack
      assign stg_waddr_s[s*AW +: AW] = waddr_r[s];
      assign stg_tnew_s[s*TW +: TW]  = tnew_r[s];
   end

   for (genvar p = 0; p < NPORT; p++) begin : g_port
      fwd_port_sel #(
         .NSTAGE (NSTAGE),
         .DW     (DW),
         .AW     (AW)
      ) u_sel (
         .addr      (rd_addr[p*AW +: AW]),
         .tuse      (rd_tuse[p*TW +: TW]),
         .rf_data   (rf_rdata[p*DW +: DW]),
         .stg_waddr (stg_waddr_s),
         .stg_tnew  (stg_tnew_s),
         .stg_wdata (stg_wdata),
         .data      (fwd_data[p*DW +: DW]),
         .hit       (fwd_hit[p*NSTAGE +: NSTAGE]),
         .stall_req (port_stall_s[p])
      );
   end

   assign md_busy   = (md_cnt_r != {CW{1'b0}});
   assign stall     = (|port_stall_s) | (md_use & md_busy);
   assign md_load_s = md_start & ~stall & ~md_busy;

   // Stage E takes the issuing instruction or a bubble; older stages shift every cycle.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int s = 0; s < NSTAGE; s++) begin
            waddr_r[s] <= {AW{1'b0}};
            tnew_r[s]  <= {TW{1'b0}};
         end
      end else begin
         if (stall) begin
            waddr_r[STG_E] <= {AW{1'b0}};
            tnew_r[STG_E]  <= {TW{1'b0}};
         end else begin
            waddr_r[STG_E] <= iss_valid ? iss_waddr : {AW{1'b0}};
            tnew_r[STG_E]  <= iss_tnew;
         end
         for (int s = 1; s < NSTAGE; s++) begin
            waddr_r[s] <= waddr_r[s-1];
            tnew_r[s]  <= tnew_dec(tnew_r[s-1]);
         end
      end
   end

   // Mult/div busy countdown; a start during a stall or while busy is dropped.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         md_cnt_r <= {CW{1'b0}};
      end else if (MD_LAT == 0) begin
         md_cnt_r <= {CW{1'b0}};
      end else if (md_load_s) begin
         md_cnt_r <= CW'(MD_LAT);
      end else if (md_busy) begin
         md_cnt_r <= md_cnt_r - CW'(1);
      end else begin
         md_cnt_r <= md_cnt_r;
      end
   end

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Self-checking bench: directed hazard scenarios plus randomized traffic, compared every
// cycle against an age-based model of what each in-flight instruction can provide.
module tb_fwd_hazard_unit;

   localparam int NPORT  = 2;
   localparam int NSTAGE = 3;
   localparam int DW     = 32;
   localparam int AW     = 5;
   localparam int MD_LAT = 5;

   logic                    clk = 1'b0;
   logic                    reset;
   logic                    iss_valid;
   logic [AW-1:0]           iss_waddr;
   logic [1:0]              iss_tnew;
   logic [NPORT*AW-1:0]     rd_addr;
   logic [NPORT*2-1:0]      rd_tuse;
   logic [NPORT*DW-1:0]     rf_rdata;
   logic [NSTAGE*DW-1:0]    stg_wdata;
   logic                    md_start;
   logic                    md_use;
   logic [NPORT*DW-1:0]     fwd_data;
   logic [NPORT*NSTAGE-1:0] fwd_hit;
   logic                    stall;
   logic                    md_busy;

   int n_checks = 0;
   int n_errors = 0;
   bit chk_en   = 1'b0;

   // Model: what entered E on each of the last NSTAGE cycles (index = age), plus mult/div end time.
   logic [AW-1:0] h_w [$];
   int            h_t [$];
   int            cyc    = 0;
   int            md_end = 0;

   fwd_hazard_unit #(
      .NPORT  (NPORT),
      .NSTAGE (NSTAGE),
      .DW     (DW),
      .AW     (AW),
      .MD_LAT (MD_LAT)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .iss_valid (iss_valid),
      .iss_waddr (iss_waddr),
      .iss_tnew  (iss_tnew),
      .rd_addr   (rd_addr),
      .rd_tuse   (rd_tuse),
      .rf_rdata  (rf_rdata),
      .stg_wdata (stg_wdata),
      .md_start  (md_start),
      .md_use    (md_use),
      .fwd_data  (fwd_data),
      .fwd_hit   (fwd_hit),
      .stall     (stall),
      .md_busy   (md_busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      h_w.delete();
      h_t.delete();
      for (int s = 0; s < NSTAGE; s++) begin
         h_w.push_back('0);
         h_t.push_back(0);
      end
      md_end = 0;
   endtask

   function automatic bit model_md_busy();
      return cyc < md_end;
   endfunction

   task automatic model_port(input int p, output logic [DW-1:0] d, output logic [NSTAGE-1:0] h,
                             output bit st);
      logic [AW-1:0] a;
      int            u;
      int            left;
      a  = rd_addr[p*AW +: AW];
      u  = int'(rd_tuse[p*2 +: 2]);
      d  = rf_rdata[p*DW +: DW];
      h  = '0;
      st = 1'b0;
      if (a != '0) begin
         for (int s = 0; s < NSTAGE; s++) begin
            if (h_w[s] == a) begin
               left = h_t[s] - s;
               if (left < 0) left = 0;
               if (left == 0) begin
                  d    = stg_wdata[s*DW +: DW];
                  h[s] = 1'b1;
               end else if (left > u) begin
                  st = 1'b1;
               end
               break;
            end
         end
      end
   endtask

   task automatic model_outputs(output logic [NPORT*DW-1:0] d, output logic [NPORT*NSTAGE-1:0] h,
                                output bit st);
      logic [DW-1:0]     pd;
      logic [NSTAGE-1:0] ph;
      bit                pst;
      st = md_use && model_md_busy();
      for (int p = 0; p < NPORT; p++) begin
         model_port(p, pd, ph, pst);
         d[p*DW +: DW]         = pd;
         h[p*NSTAGE +: NSTAGE] = ph;
         st                    = st | pst;
      end
   endtask

   task automatic model_edge();
      logic [NPORT*DW-1:0]     d;
      logic [NPORT*NSTAGE-1:0] h;
      bit                      st;
      if (reset) begin
         model_reset();
      end else begin
         model_outputs(d, h, st);
         if (md_start && !st && !model_md_busy() && MD_LAT > 0) md_end = cyc + 1 + MD_LAT;
         void'(h_w.pop_back());
         void'(h_t.pop_back());
         h_w.push_front(st ? '0 : (iss_valid ? iss_waddr : '0));
         h_t.push_front(st ? 0 : int'(iss_tnew));
      end
      cyc++;
   endtask

   task automatic tick();
      @(posedge clk);
      model_edge();
      #1;
   endtask

   task automatic settle();
      @(negedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      iss_valid = 1'b0;
      iss_waddr = '0;
      iss_tnew  = '0;
      rd_addr   = '0;
      rd_tuse   = '0;
      md_start  = 1'b0;
      md_use    = 1'b0;
      for (int p = 0; p < NPORT; p++) rf_rdata[p*DW +: DW] = DW'($urandom);
      for (int s = 0; s < NSTAGE; s++) stg_wdata[s*DW +: DW] = DW'($urandom);
   endtask

   task automatic rand_inputs();
      idle_inputs();
      iss_valid = 1'($urandom_range(0, 1));
      iss_waddr = AW'($urandom_range(0, 7));
      iss_tnew  = 2'($urandom_range(0, 3));
      for (int p = 0; p < NPORT; p++) begin
         rd_addr[p*AW +: AW] = AW'($urandom_range(0, 7));
         rd_tuse[p*2 +: 2]   = 2'($urandom_range(0, 3));
      end
      md_start = ($urandom_range(0, 7) == 0);
      md_use   = ($urandom_range(0, 3) == 0);
   endtask

   // Every cycle outside reset, DUT outputs must equal the model's view.
   always @(negedge clk) begin
      logic [NPORT*DW-1:0]     ed;
      logic [NPORT*NSTAGE-1:0] eh;
      bit                      est;
      if (chk_en && !reset) begin
         model_outputs(ed, eh, est);
         check("fwd_data", fwd_data, ed);
         check("fwd_hit", fwd_hit, eh);
         check("stall", stall, est);
         check("md_busy", md_busy, model_md_busy());
      end
   end

   initial begin
      int stall_cnt;
      reset = 1'b1;
      idle_inputs();
      model_reset();
      tick();
      tick();
      reset = 1'b0;
      chk_en = 1'b1;

      // After reset: no forwarding from empty pipeline.
      idle_inputs();
      rd_addr = {AW'(8), AW'(8)};
      settle();
      check("rst_hit", fwd_hit, 6'b000000);
      check("rst_data", fwd_data, rf_rdata);
      check("rst_stall", stall, 1'b0);
      check("rst_busy", md_busy, 1'b0);

      // Forward from E.
      iss_valid = 1'b1;
      iss_waddr = AW'(8);
      iss_tnew  = 2'd0;
      tick();
      idle_inputs();
      rd_addr[0 +: AW] = AW'(8);
      rd_tuse[0 +: 2]  = 2'd1;
      settle();
      check("e_hit", fwd_hit[2:0], 3'b001);
      check("e_data", fwd_data[0 +: DW], stg_wdata[0 +: DW]);
      check("e_stall", stall, 1'b0);

      // Load-use: two stall cycles, then forward from W.
      tick();
      idle_inputs();
      iss_valid = 1'b1;
      iss_waddr = AW'(9);
      iss_tnew  = 2'd2;
      tick();
      idle_inputs();
      rd_addr[0 +: AW] = AW'(9);
      settle();
      check("lu_stall1", stall, 1'b1);
      tick();
      settle();
      check("lu_stall2", stall, 1'b1);
      tick();
      settle();
      check("lu_stall3", stall, 1'b0);
      check("lu_hit", fwd_hit[2:0], 3'b100);
      check("lu_data", fwd_data[0 +: DW], stg_wdata[2*DW +: DW]);

      // Two producers of r4: youngest wins.
      idle_inputs();
      iss_valid = 1'b1;
      iss_waddr = AW'(4);
      tick();
      tick();
      idle_inputs();
      rd_addr = {AW'(4), AW'(4)};
      rd_tuse = {2'd3, 2'd0};
      stg_wdata[DW +: DW] = ~stg_wdata[0 +: DW];
      settle();
      check("prio_hit", fwd_hit, 6'b001001);
      check("prio_data0", fwd_data[0 +: DW], stg_wdata[0 +: DW]);
      check("prio_data1", fwd_data[DW +: DW], stg_wdata[0 +: DW]);

      // Invalid issue becomes a bubble; rd_addr 0 never forwards.
      idle_inputs();
      iss_waddr = AW'(4);
      tick();
      idle_inputs();
      settle();
      check("zero_hit", fwd_hit, 6'b000000);
      check("zero_stall", stall, 1'b0);
      check("zero_data", fwd_data, rf_rdata);
      rd_addr[AW +: AW] = AW'(4);
      #1;
      check("bubble_hit", fwd_hit[5:3], 3'b010);

      // Mult/div: md_use held high stalls for MD_LAT cycles.
      idle_inputs();
      md_start = 1'b1;
      tick();
      md_start  = 1'b0;
      md_use    = 1'b1;
      stall_cnt = 0;
      for (int i = 0; i < 8; i++) begin
         settle();
         if (stall) stall_cnt++;
         tick();
      end
      check("md_stall_cycles", 32'(stall_cnt), 32'd5);

      // Async reset in the middle of a mult/div.
      md_use   = 1'b0;
      md_start = 1'b1;
      tick();
      md_start = 1'b0;
      md_use   = 1'b1;
      tick();
      tick();
      #1;
      check("md_busy_mid", md_busy, 1'b1);
      reset = 1'b1;
      model_reset();
      #1;
      check("md_busy_rst", md_busy, 1'b0);
      check("md_stall_rst", stall, 1'b0);
      tick();
      #1;
      reset = 1'b0;
      idle_inputs();

      // Randomized traffic with occasional resets.
      for (int i = 0; i < 800; i++) begin
         if (reset) begin
            reset = 1'b0;
         end else if ($urandom_range(0, 99) == 0) begin
            reset = 1'b1;
            model_reset();
         end
         rand_inputs();
         tick();
      end
      reset = 1'b0;
      settle();
      chk_en = 1'b0;

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
